// File: rtl/inst_prog_sequencer.sv
// inst_prog_sequencer: arbitrates host/stream instruction loads, then drives PC reset, start and run-complete.
// Define INST_PROG_SEQ_CHECKSUM_EN to build the XOR checksum of written words.
module inst_prog_sequencer #(
  parameter int DataWidth        = 32,
  parameter int InstMemDepth     = 128,
  parameter int InstMemAddrWidth = 8,
  parameter int CntWidth         = $clog2(InstMemDepth) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        host_valid_i,
  output logic                        host_ready_o,
  input  logic [DataWidth-1:0]        host_data_i,
  input  logic                        host_last_i,
  input  logic [InstMemAddrWidth-1:0] host_base_i,
  input  logic                        strm_valid_i,
  output logic                        strm_ready_o,
  input  logic [DataWidth-1:0]        strm_data_i,
  input  logic                        strm_last_i,
  input  logic [InstMemAddrWidth-1:0] strm_base_i,
  input  logic                        auto_run_i,
  input  logic                        run_i,
  input  logic                        enable_i,
  output logic                        inst_wr_mode_o,
  output logic [InstMemAddrWidth-1:0] inst_wr_addr_o,
  output logic                        inst_wr_addr_en_o,
  output logic [DataWidth-1:0]        inst_wr_data_o,
  output logic                        inst_wr_data_en_o,
  output logic                        inst_pc_reset_o,
  output logic                        start_o,
  output logic [1:0]                  grant_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_ovf_o,
  output logic [DataWidth-1:0]        checksum_o
);
  localparam int OvfWidth = (InstMemAddrWidth > CntWidth ? InstMemAddrWidth : CntWidth) + 1;
  typedef enum logic [2:0] {IDLE, ADDR, LOAD, ARM, START, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic ptr_q, ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [InstMemAddrWidth-1:0] base_q, base_d, sel_base;
  logic seen_en_q, seen_en_d, err_ovf_q, err_ovf_d;
  logic [DataWidth-1:0] sel_data;
  logic sel_valid, sel_last, load, beat, ovf;
  assign sel_valid = grant_q[1] ? strm_valid_i : host_valid_i;
  assign sel_last  = grant_q[1] ? strm_last_i  : host_last_i;
  assign sel_data  = grant_q[1] ? strm_data_i  : host_data_i;
  assign sel_base  = grant_q[1] ? strm_base_i  : host_base_i;
  // widened so base + count past the end of memory never wraps back in range
  assign ovf  = (OvfWidth'(base_q) + OvfWidth'(cnt_q)) >= OvfWidth'(InstMemDepth);
  assign load = (state_q == LOAD) && !clr_i;
  assign beat = load && sel_valid;
  assign host_ready_o      = load && grant_q[0];
  assign strm_ready_o      = load && grant_q[1];
  assign inst_wr_mode_o    = (state_q == ADDR) || (state_q == LOAD);
  assign inst_wr_addr_en_o = (state_q == ADDR) && !clr_i;
  assign inst_wr_addr_o    = (state_q == ADDR) ? sel_base : '0;
  assign inst_wr_data_o    = (state_q == LOAD) ? sel_data : '0;
  assign inst_wr_data_en_o = beat && !ovf;
  assign inst_pc_reset_o   = (state_q == ARM) && !clr_i;
  assign start_o           = (state_q == START) && !clr_i;
  assign done_o            = (state_q == DONE) && !clr_i;
  assign busy_o            = state_q != IDLE;
  assign grant_o           = grant_q;
  assign err_ovf_o         = err_ovf_q;
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    seen_en_d = seen_en_q;
    err_ovf_d = err_ovf_q;
    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d = ARM;
        end else if (host_valid_i || strm_valid_i) begin
          grant_d = (strm_valid_i && (!host_valid_i || ptr_q)) ? 2'b10 : 2'b01;
          ptr_d   = grant_d[0];
          state_d = ADDR;
        end
      end
      ADDR: begin
        base_d    = sel_base;
        cnt_d     = '0;
        err_ovf_d = 1'b0;
        state_d   = LOAD;
      end
      LOAD: begin
        if (beat) begin
          err_ovf_d = err_ovf_q || ovf;
          cnt_d     = ovf ? cnt_q : cnt_q + CntWidth'(1);
          if (sel_last) begin
            grant_d = '0;
            state_d = auto_run_i ? ARM : IDLE;
          end
        end
      end
      ARM: begin
        seen_en_d = 1'b0;
        state_d   = START;
      end
      START: state_d = RUN;
      RUN: begin
        seen_en_d = seen_en_q || enable_i;
        state_d   = (!enable_i && seen_en_q) ? DONE : RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d   = IDLE;
      grant_d   = '0;
      ptr_d     = 1'b0;
      cnt_d     = '0;
      seen_en_d = 1'b0;
      err_ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      base_q    <= '0;
      seen_en_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      seen_en_q <= seen_en_d;
      err_ovf_q <= err_ovf_d;
    end
  end
`ifdef INST_PROG_SEQ_CHECKSUM_EN
  logic [DataWidth-1:0] chk_q, chk_d;
  assign chk_d = (clr_i || state_q == ADDR) ? '0 :
                 inst_wr_data_en_o ? chk_q ^ inst_wr_data_o : chk_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) chk_q <= '0;
    else chk_q <= chk_d;
  end
  assign checksum_o = chk_q;
`else
  assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_inst_prog_sequencer.sv
// tb_inst_prog_sequencer: directed checks of arbitration, load, overflow, run sequencing, clear and checksum.
module tb_inst_prog_sequencer;
  logic clk_i = 0, rst_ni = 0, clr_i = 0;
  logic host_valid_i = 0, host_last_i = 0, strm_valid_i = 0, strm_last_i = 0;
  logic [31:0] host_data_i = '0, strm_data_i = '0;
  logic [7:0] host_base_i = '0, strm_base_i = '0;
  logic auto_run_i = 0, run_i = 0, enable_i = 0;
  logic host_ready_o, strm_ready_o, inst_wr_mode_o, inst_wr_addr_en_o, inst_wr_data_en_o;
  logic inst_pc_reset_o, start_o, busy_o, done_o, err_ovf_o;
  logic [7:0] inst_wr_addr_o;
  logic [31:0] inst_wr_data_o, checksum_o;
  logic [1:0] grant_o;
`ifdef INST_PROG_SEQ_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif
  int n_checks = 0, n_errors = 0;
  int n_start = 0, n_aen = 0, n_den = 0;
  int s0, a0, d0;

  inst_prog_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o), .host_data_i(host_data_i),
    .host_last_i(host_last_i), .host_base_i(host_base_i),
    .strm_valid_i(strm_valid_i), .strm_ready_o(strm_ready_o), .strm_data_i(strm_data_i),
    .strm_last_i(strm_last_i), .strm_base_i(strm_base_i),
    .auto_run_i(auto_run_i), .run_i(run_i), .enable_i(enable_i),
    .inst_wr_mode_o(inst_wr_mode_o), .inst_wr_addr_o(inst_wr_addr_o),
    .inst_wr_addr_en_o(inst_wr_addr_en_o), .inst_wr_data_o(inst_wr_data_o),
    .inst_wr_data_en_o(inst_wr_data_en_o), .inst_pc_reset_o(inst_pc_reset_o),
    .start_o(start_o), .grant_o(grant_o), .busy_o(busy_o), .done_o(done_o),
    .err_ovf_o(err_ovf_o), .checksum_o(checksum_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (start_o) n_start++;
    if (inst_wr_addr_en_o) n_aen++;
    if (inst_wr_data_en_o) n_den++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    host_valid_i = 0; strm_valid_i = 0; host_last_i = 0; strm_last_i = 0;
    run_i = 0; enable_i = 0; auto_run_i = 0; clr_i = 0;
  endtask

  initial begin
    #3;
    check("rst_busy", busy_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_done", done_o, 0);
    check("rst_start", start_o, 0);
    check("rst_pcr", inst_pc_reset_o, 0);
    check("rst_mode", inst_wr_mode_o, 0);
    check("rst_err", err_ovf_o, 0);
    check("rst_chk", checksum_o, 0);
    check("rst_hready", host_ready_o, 0);
    check("rst_sready", strm_ready_o, 0);
    tick(); tick();
    rst_ni = 1;
    tick();

    // both requesters valid right after reset: host first, then stream
    host_valid_i = 1; strm_valid_i = 1; host_last_i = 1; strm_last_i = 1;
    host_base_i = 8'h20; strm_base_i = 8'h30; host_data_i = 32'hB0; strm_data_i = 32'hC0;
    tick();
    check("b_grant_host", grant_o, 2'b01);
    check("b_addr_host", inst_wr_addr_o, 8'h20);
    tick();
    check("b_hready", host_ready_o, 1);
    check("b_sready_blocked", strm_ready_o, 0);
    check("b_hdata", inst_wr_data_o, 32'hB0);
    tick();
    check("b_release", grant_o, 0);
    tick();
    check("b_grant_strm", grant_o, 2'b10);
    check("b_addr_strm", inst_wr_addr_o, 8'h30);
    tick();
    check("b_sready", strm_ready_o, 1);
    check("b_hready_blocked", host_ready_o, 0);
    check("b_sdata", inst_wr_data_o, 32'hC0);
    tick();
    idle_in();

    // host session, base 0x10, four words, no auto-run
    s0 = n_start; a0 = n_aen; d0 = n_den;
    host_base_i = 8'h10; host_valid_i = 1; host_data_i = 32'hA0;
    #1;
    check("a_idle_ready", host_ready_o, 0);
    tick();
    check("a_addr_en", inst_wr_addr_en_o, 1);
    check("a_addr", inst_wr_addr_o, 8'h10);
    check("a_mode", inst_wr_mode_o, 1);
    check("a_addr_ready", host_ready_o, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      host_data_i = 32'hA0 + i; host_last_i = (i == 3);
      #1;
      check("a_den", inst_wr_data_en_o, 1);
      check("a_data", inst_wr_data_o, 32'hA0 + i);
      tick();
    end
    idle_in();
    #1;
    check("a_busy", busy_o, 0);
    check("a_mode_off", inst_wr_mode_o, 0);
    repeat (3) tick();
    check("a_addr_cnt", n_aen - a0, 1);
    check("a_den_cnt", n_den - d0, 4);
    check("a_no_start", n_start - s0, 0);

    // stream session at 0x7E overruns the end of memory
    d0 = n_den;
    strm_base_i = 8'h7E; strm_valid_i = 1;
    tick();
    check("c_addr", inst_wr_addr_o, 8'h7E);
    tick();
    for (int i = 0; i < 4; i++) begin
      strm_data_i = 32'hD0 + i; strm_last_i = (i == 3);
      #1;
      check("c_ready", strm_ready_o, 1);
      check("c_den", inst_wr_data_en_o, i < 2);
      check("c_err", err_ovf_o, i == 3);
      tick();
    end
    idle_in();
    #1;
    check("c_done_load", busy_o, 0);
    check("c_err_sticky", err_ovf_o, 1);
    check("c_den_cnt", n_den - d0, 2);

    // auto-run: last beat at N, enable high N+3..N+9, done at N+11
    host_base_i = 8'h00; host_valid_i = 1; host_last_i = 1; host_data_i = 32'hE0; auto_run_i = 1;
    tick();
    tick();
    check("d_err_cleared", err_ovf_o, 0);
    check("d_den", inst_wr_data_en_o, 1);
    tick();
    idle_in();
    #1;
    check("d_pcr", inst_pc_reset_o, 1);
    check("d_pcr_nostart", start_o, 0);
    tick();
    check("d_start", start_o, 1);
    check("d_start_nopcr", inst_pc_reset_o, 0);
    for (int i = 3; i <= 9; i++) begin
      tick();
      enable_i = 1;
      #1;
      check("d_run_nodone", done_o, 0);
      check("d_run_noready", host_ready_o, 0);
    end
    tick();
    enable_i = 0;
    #1;
    check("d_fall_nodone", done_o, 0);
    tick();
    check("d_done", done_o, 1);
    tick();
    check("d_done_pulse", done_o, 0);
    check("d_idle", busy_o, 0);

    // run_i from IDLE without a load; a run_i while running is ignored
    run_i = 1;
    #1;
    check("e_idle", busy_o, 0);
    tick();
    run_i = 0;
    #1;
    check("e_pcr", inst_pc_reset_o, 1);
    tick();
    check("e_start", start_o, 1);
    tick();
    enable_i = 1; run_i = 1;
    #1;
    check("e_run", busy_o, 1);
    tick();
    enable_i = 0; run_i = 0;
    #1;
    check("e_nodone", done_o, 0);
    tick();
    check("e_done", done_o, 1);
    tick();
    check("e_idle_after", busy_o, 0);
    tick();
    check("e_no_rerun", inst_pc_reset_o, 0);

    // clear in the middle of an overflowing load
    host_base_i = 8'h7F; host_valid_i = 1; host_data_i = 32'h11;
    tick();
    tick();
    check("f_den0", inst_wr_data_en_o, 1);
    tick();
    check("f_den1_ovf", inst_wr_data_en_o, 0);
    tick();
    check("f_err_set", err_ovf_o, 1);
    clr_i = 1;
    #1;
    check("f_clr_noready", host_ready_o, 0);
    check("f_clr_noden", inst_wr_data_en_o, 0);
    tick();
    clr_i = 0; strm_valid_i = 1; host_base_i = 8'h50; strm_base_i = 8'h60;
    #1;
    check("f_idle", busy_o, 0);
    check("f_mode", inst_wr_mode_o, 0);
    check("f_err_clr", err_ovf_o, 0);
    check("f_grant_clr", grant_o, 0);
    check("f_ready", host_ready_o, 0);
    tick();
    check("f_regrant_host", grant_o, 2'b01);
    check("f_addr_en", inst_wr_addr_en_o, 1);
    check("f_addr", inst_wr_addr_o, 8'h50);
    tick();
    strm_valid_i = 0; host_last_i = 1; host_data_i = 32'h55;
    #1;
    check("f_den", inst_wr_data_en_o, 1);
    tick();
    idle_in();

    // checksum over words 1, 2, 4
    host_base_i = 8'h00; host_valid_i = 1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      host_data_i = 32'h1 << i; host_last_i = (i == 2);
      #1;
      check("g_chk_run", checksum_o, ChkEn ? ((32'h1 << i) - 1) : 32'h0);
      tick();
    end
    idle_in();
    #1;
    check("g_chk_final", checksum_o, ChkEn ? 32'h7 : 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
